// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls payload words from an upstream registered-read FIFO.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for fifo_empty=0 to request a pop
// POP    | pop issued, waiting out the FIFO read latency
// LOAD   | capture fifo_rd_data, clear bit and baud counters
// START  | start bit (0) for CLKS_PER_BIT cycles
// DATA   | DATA_WIDTH payload bits, LSB first
// PARITY | even-parity bit (only with FIFO_UART_TX_PARITY_EN)
// STOP   | stop bit (1); tx_done on the final line cycle
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 0) ? $clog2(DATA_WIDTH + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd6
  } state_t;
`endif

  state_t                state;
  state_t                next_state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  bit_end;
  logic                  rd_en_next;
  logic                  tx_next;
  logic                  busy_next;
  logic                  done_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    rd_en_next = 1'b0;
    tx_next    = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = POP;
          rd_en_next = 1'b1;
        end
      end
      POP:  next_state = LOAD;
      LOAD: next_state = START;
      START: begin
        tx_next = 1'b0;
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        tx_next = shift_q[0];
        if (bit_end && (bit_cnt == BIT_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (bit_end) next_state = STOP;
      end
`endif
      STOP: begin
        done_next = bit_end;
        if (bit_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Outputs are registered, so busy also spans the cycle in which the stop bit leaves the pin.
    busy_next = (state != IDLE) || (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          shift_q  <= fifo_rd_data;
          baud_cnt <= '0;
          bit_cnt  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= ^fifo_rd_data;
`endif
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
            shift_q  <= shift_q >> 1;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        START, PARITY, STOP: begin
`else
        START, STOP: begin
`endif
          baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
        end
        default: baud_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      fifo_rd_en <= rd_en_next;
      tx         <= tx_next;
      busy       <= busy_next;
      tx_done    <= done_next;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4) with a small registered-read FIFO model.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic [7:0] fifo_mem [0:15];
  int         wp = 0;
  int         rp = 0;
  logic       tgl_en = 1'b0;
  logic       tgl_val = 1'b1;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int low_cnt = 0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = tgl_en ? tgl_val : (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en && (rp != wp)) begin
      fifo_rd_data <= fifo_mem[rp % 16];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt++;
    if (busy) busy_cnt++;
    if (tx_done) done_cnt++;
    if (!tx) low_cnt++;
    if (tgl_en) tgl_val = ~tgl_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wp % 16] = b;
    wp++;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_rd_en(output int waited);
    waited = 0;
    while (!fifo_rd_en && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!fifo_rd_en) check("rd_en_timeout", 32'd0, 32'd1);
  endtask

  // Entered on a negedge; returns on the negedge just after the stop bit's last cycle.
  task automatic expect_frame(input logic [7:0] b, input bit b2b, input bit tgl);
    int w;
    wait_rd_en(w);
    if (b2b) check("gap_cycles", w, 0);
    for (int p = 0; p < 3; p++) begin
      check("pre_tx", tx, 1);
      check("pre_busy", busy, 1);
      @(negedge clk);
    end
    for (int i = 0; i < NBITS; i++) begin
      tgl_en = tgl && (i < NBITS - 1);
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("tx_bit%0d_%02h", i, b), tx, exp_bit(b, i));
        check("tx_done", tx_done, (i == NBITS - 1) && (c == CPB - 1));
        check("busy", busy, 1);
        @(negedge clk);
      end
    end
    tgl_en = 1'b0;
  endtask

  initial begin
    int rd0, busy0, done0, low0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_done", tx_done, 0);
    rst_n = 1'b1;

    // Empty FIFO: nothing happens for 100 cycles
    rd0 = rd_cnt; busy0 = busy_cnt; low0 = low_cnt;
    repeat (100) @(negedge clk);
    check("idle_rd_en", rd_cnt - rd0, 0);
    check("idle_busy", busy_cnt - busy0, 0);
    check("idle_tx_low", low_cnt - low0, 0);

    // Single byte 0xA5
    rd0 = rd_cnt; busy0 = busy_cnt; done0 = done_cnt;
    push(8'hA5);
    expect_frame(8'hA5, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("a5_rd_pulses", rd_cnt - rd0, 1);
    check("a5_done_pulses", done_cnt - done0, 1);
    check("a5_busy_cycles", busy_cnt - busy0, 3 + NBITS * CPB);
    check("a5_idle_busy", busy, 0);

    // Back-to-back frames, order preserved
    rd0 = rd_cnt; done0 = done_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    expect_frame(8'h00, 1'b0, 1'b0);
    expect_frame(8'hFF, 1'b1, 1'b0);
    expect_frame(8'h3C, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("b2b_rd_pulses", rd_cnt - rd0, 3);
    check("b2b_done_pulses", done_cnt - done0, 3);

    // Odd-weight byte
    push(8'h01);
    expect_frame(8'h01, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // fifo_empty toggling mid-frame
    rd0 = rd_cnt;
    push(8'h96);
    expect_frame(8'h96, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("tgl_rd_pulses", rd_cnt - rd0, 1);

    // Reset during bit 4 of 0x5A; next byte 0xC3 follows intact
    push(8'h5A); push(8'hC3);
    begin
      int w;
      wait_rd_en(w);
    end
    repeat (24) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_tx", tx, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", tx_done, 0);
    rd0 = rd_cnt;
    repeat (3) @(negedge clk);
    check("held_rst_rd_en", rd_cnt - rd0, 0);
    check("held_rst_busy", busy, 0);
    rst_n = 1'b1;
    expect_frame(8'hC3, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("post_rst_drained", (wp == rp) ? 1 : 0, 1);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
